// File: rtl/wb_master_traffic_gen_pkg.sv
// Shared definitions for the Wishbone traffic generator.
//   tg_state_e   : sweep FSM states
//   LFSR_POLY    : Galois LFSR feedback polynomial for the pseudo-random data option
//   LFSR_SEED    : base seed, OR-ed with the loop index at each phase start
//   CNT_WIDTH    : width of the error / mismatch counters
//   sat_inc      : saturating increment for the status counters
//   lfsr_step    : one right-shift Galois LFSR step
package wb_tg_pkg;

  localparam int unsigned CNT_WIDTH = 16;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_0000;

  typedef enum logic [2:0] {
    DELAY,
    WR_REQ,
    RD_REQ,
    GAP,
    DONE
  } tg_state_e;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/wb_master_traffic_gen_if.sv
// Wishbone classic bus bundle between the traffic generator and a slave port.
//   cyc_o, stb_o, we_o, adr_o, dat_o, sel_o : master -> slave
//   dat_i, ack_i, err_i                     : slave -> master
// Signal names keep the master-side suffixes of the original flat port list.
interface wb_master_traffic_gen_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned GRANULE    = 8
);
  localparam int unsigned SEL_WIDTH = DATA_WIDTH / GRANULE;

  logic                  cyc_o;
  logic                  stb_o;
  logic                  we_o;
  logic [ADDR_WIDTH-1:0] adr_o;
  logic [DATA_WIDTH-1:0] dat_o;
  logic [SEL_WIDTH-1:0]  sel_o;
  logic [DATA_WIDTH-1:0] dat_i;
  logic                  ack_i;
  logic                  err_i;

  modport master (
    output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
    input  dat_i, ack_i, err_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
    output dat_i, ack_i, err_i
  );

endinterface

// File: rtl/wb_master_traffic_gen_pattern.sv
// Data pattern source for the traffic generator (module wb_tg_pattern_gen).
//   clk_i, rst_i : clock, asynchronous active-low reset
//   seed         : load seed (LFSR_SEED | seed_idx) for a new phase
//   advance      : step the generator after a completed beat
//   seed_idx     : loop index used for seeding
//   loop_idx     : current loop index (address-derived pattern)
//   adr          : current beat address (address-derived pattern)
//   data         : expected / write data for the current beat
// Macro WB_TG_LFSR_DATA_EN selects a 32-bit Galois LFSR replicated to
// DATA_WIDTH; otherwise data is the zero-extended address XOR loop parity.
module wb_tg_pattern_gen
  import wb_tg_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  seed,
  input  logic                  advance,
  input  logic [15:0]           seed_idx,
  input  logic [15:0]           loop_idx,
  input  logic [ADDR_WIDTH-1:0] adr,
  output logic [DATA_WIDTH-1:0] data
);

`ifdef WB_TG_LFSR_DATA_EN
  localparam int unsigned REPS = (DATA_WIDTH + 31) / 32;

  logic [31:0] lfsr;

  // Seed wins over advance: the last beat of a phase reseeds for the next one.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lfsr <= LFSR_SEED;
    end else if (seed) begin
      lfsr <= LFSR_SEED | {16'h0, seed_idx};
    end else if (advance) begin
      lfsr <= lfsr_step(lfsr);
    end
  end

  assign data = DATA_WIDTH'({REPS{lfsr}});

  logic unused_pattern;
  assign unused_pattern = &{1'b0, adr, loop_idx};
`else
  assign data = DATA_WIDTH'(adr) ^ {DATA_WIDTH{loop_idx[0]}};

  logic unused_pattern;
  assign unused_pattern = &{1'b0, clk_i, rst_i, seed, advance, seed_idx, loop_idx[15:1]};
`endif

endmodule

// File: rtl/wb_master_traffic_gen.sv
// Wishbone classic master running write-then-readback sweeps over
// [START_ADDR, END_ADDR] with STRIDE, for LOOPS passes (0 = forever),
// self-checking read data and counting errors / timeouts.
//   clk_i, rst_i      : clock, asynchronous active-low reset
//   wb (master)       : Wishbone bus bundle
//   done_o            : all loops complete (sticky until reset)
//   pass_o            : done_o with zero errors and zero mismatches
//   err_cnt_o         : err_i responses + timeouts, saturating
//   mismatch_cnt_o    : read-compare failures, saturating
// Optional macro WB_TG_LFSR_DATA_EN selects LFSR data (see wb_tg_pattern_gen).
module wb_master_traffic_gen
  import wb_tg_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = 16,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           GRANULE        = 8,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR     = 'h2000,
  parameter logic [ADDR_WIDTH-1:0] END_ADDR       = 'h200f,
  parameter int unsigned           STRIDE         = 1,
  parameter int unsigned           LOOPS          = 1,
  parameter int unsigned           INITIAL_DELAY  = 1,
  parameter int unsigned           WAIT_CYCLES    = 0,
  parameter int unsigned           TIMEOUT_CYCLES = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  wb_master_traffic_gen_if.master wb,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o,
  output logic [CNT_WIDTH-1:0] mismatch_cnt_o
);

  localparam int unsigned SEL_WIDTH = DATA_WIDTH / GRANULE;

  tg_state_e             state;
  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [ADDR_WIDTH-1:0] adr;
  logic [31:0]           loop_cnt;
  logic [31:0]           delay_cnt;
  logic [31:0]           wait_cnt;
  logic [31:0]           gap_cnt;
  logic [CNT_WIDTH-1:0]  err_cnt;
  logic [CNT_WIDTH-1:0]  mism_cnt;
  logic                  done;

  logic                  resp;
  logic                  tmo;
  logic                  beat_end;
  logic [ADDR_WIDTH:0]   nxt;
  logic                  last;
  logic                  final_beat;
  tg_state_e             next_req;
  logic                  seed;
  logic                  advance;
  logic [15:0]           seed_idx;
  logic [DATA_WIDTH-1:0] pattern;

  always_comb begin
    resp       = wb.ack_i | wb.err_i;
    tmo        = (TIMEOUT_CYCLES != 0) && !resp && (wait_cnt == TIMEOUT_CYCLES - 1);
    beat_end   = ((state == WR_REQ) || (state == RD_REQ)) && (resp || tmo);
    // Extra MSB catches wrap-around past the top of the address space.
    nxt        = {1'b0, adr} + (ADDR_WIDTH+1)'(STRIDE);
    last       = nxt > {1'b0, END_ADDR};
    final_beat = last && (state == RD_REQ) && (LOOPS != 0) && (loop_cnt + 32'd1 == LOOPS);
    next_req   = state;
    if (last) next_req = (state == WR_REQ) ? RD_REQ : WR_REQ;
    seed       = ((state == DELAY) && (delay_cnt >= INITIAL_DELAY)) || (beat_end && last);
    advance    = beat_end;
    seed_idx   = (state == RD_REQ) ? loop_cnt[15:0] + 16'd1 : loop_cnt[15:0];
  end

  wb_tg_pattern_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_pattern (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .seed     (seed),
    .advance  (advance),
    .seed_idx (seed_idx),
    .loop_idx (loop_cnt[15:0]),
    .adr      (adr),
    .data     (pattern)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= DELAY;
      cyc       <= 1'b0;
      stb       <= 1'b0;
      we        <= 1'b0;
      adr       <= START_ADDR;
      loop_cnt  <= '0;
      delay_cnt <= '0;
      wait_cnt  <= '0;
      gap_cnt   <= '0;
      err_cnt   <= '0;
      mism_cnt  <= '0;
      done      <= 1'b0;
    end else begin
      case (state)
        DELAY: begin
          if (delay_cnt >= INITIAL_DELAY) begin
            state <= WR_REQ;
            cyc   <= 1'b1;
            stb   <= 1'b1;
            we    <= 1'b1;
          end else begin
            delay_cnt <= delay_cnt + 32'd1;
          end
        end

        WR_REQ, RD_REQ: begin
          if (!beat_end) begin
            wait_cnt <= wait_cnt + 32'd1;
          end else begin
            wait_cnt <= '0;
            // err_i (alone or with ack_i) and timeouts count as errors, never compared.
            if (wb.err_i || tmo) begin
              err_cnt <= sat_inc(err_cnt);
            end else if ((state == RD_REQ) && (wb.dat_i != pattern)) begin
              mism_cnt <= sat_inc(mism_cnt);
            end

            if (!last) begin
              adr <= nxt[ADDR_WIDTH-1:0];
            end else begin
              adr <= START_ADDR;
              if (state == WR_REQ) begin
                we <= 1'b0;
              end else begin
                loop_cnt <= loop_cnt + 32'd1;
                we       <= 1'b1;
              end
            end

            if (final_beat) begin
              state <= DONE;
              cyc   <= 1'b0;
              stb   <= 1'b0;
              we    <= 1'b0;
              done  <= 1'b1;
            end else if ((WAIT_CYCLES == 0) && !tmo) begin
              state <= next_req;
            end else begin
              // An aborted beat always releases the bus for at least one cycle.
              state   <= GAP;
              cyc     <= 1'b0;
              stb     <= 1'b0;
              gap_cnt <= '0;
            end
          end
        end

        GAP: begin
          if (gap_cnt + 32'd1 >= WAIT_CYCLES) begin
            state <= we ? WR_REQ : RD_REQ;
            cyc   <= 1'b1;
            stb   <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 32'd1;
          end
        end

        DONE: begin
          cyc <= 1'b0;
          stb <= 1'b0;
        end

        default: state <= DELAY;
      endcase
    end
  end

  assign wb.cyc_o       = cyc;
  assign wb.stb_o       = stb;
  assign wb.we_o        = we;
  assign wb.adr_o       = adr;
  assign wb.dat_o       = (cyc && we) ? pattern : '0;
  assign wb.sel_o       = {SEL_WIDTH{cyc}};
  assign done_o         = done;
  assign pass_o         = done && (err_cnt == '0) && (mism_cnt == '0);
  assign err_cnt_o      = err_cnt;
  assign mismatch_cnt_o = mism_cnt;

endmodule

// File: tb/tb_wb_master_traffic_gen.sv
`timescale 1ns/1ps
module tb_wb_master_traffic_gen;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned NLOOP = 2;
  localparam int unsigned NBEAT = 16;
  localparam int unsigned TMO   = 16;
  localparam logic [15:0] START = 16'h2000;
`ifdef WB_TG_LFSR_DATA_EN
  localparam logic [31:0] FIRST_DAT = 32'hACE1_0000;
`else
  localparam logic [31:0] FIRST_DAT = 32'h0000_2000;
`endif

  typedef enum int {M_NORMAL, M_CORRUPT, M_ERR, M_NOACK} mode_e;
  typedef struct packed {
    logic        we;
    logic [15:0] adr;
    logic [31:0] dat;
  } beat_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        done;
  logic        pass;
  logic [15:0] err_cnt;
  logic [15:0] mism_cnt;
  mode_e       mode  = M_NORMAL;

  beat_t       exp_q[$];
  int          vectors = 0;
  int          fails   = 0;
  int          hold    = 0;
  bit          expect_drop = 1'b0;

  logic [31:0] mem [16];
  logic        s_ack;
  logic        s_err;
  logic [31:0] s_rd;
  logic [3:0]  s_idx;

  wb_master_traffic_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8)) wb ();

  wb_master_traffic_gen #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .GRANULE        (8),
    .START_ADDR     (16'h2000),
    .END_ADDR       (16'h200f),
    .STRIDE         (1),
    .LOOPS          (NLOOP),
    .INITIAL_DELAY  (1),
    .WAIT_CYCLES    (0),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .wb             (wb),
    .done_o         (done),
    .pass_o         (pass),
    .err_cnt_o      (err_cnt),
    .mismatch_cnt_o (mism_cnt)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Expected beat stream for a full run: per loop, 16 writes then 16 reads.
  task automatic push_sweep();
    logic [31:0] s;
    logic [31:0] d;
    logic [15:0] a;
    for (int unsigned l = 0; l < NLOOP; l++) begin
      for (int p = 0; p < 2; p++) begin
        s = 32'hACE1_0000 | l;
        for (int unsigned k = 0; k < NBEAT; k++) begin
          a = START + 16'(k);
`ifdef WB_TG_LFSR_DATA_EN
          d = s;
`else
          d = {16'h0, a} ^ {32{l[0]}};
`endif
          s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
          exp_q.push_back('{we: (p == 0), adr: a, dat: d});
        end
      end
    end
  endtask

  // Slave register file with fault injection, responding in the same cycle.
  initial begin
    wb.ack_i = 1'b0;
    wb.err_i = 1'b0;
    wb.dat_i = '0;
    forever begin
      @(negedge clk);
      s_ack = 1'b0;
      s_err = 1'b0;
      s_rd  = 32'h0;
      if (!rst_n) begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      end else if (wb.cyc_o && wb.stb_o && mode != M_NOACK) begin
        s_idx = wb.adr_o[3:0];
        if (wb.we_o) begin
          if (mode == M_ERR && wb.adr_o == 16'h2003) begin
            s_err = 1'b1;
          end else begin
            s_ack = 1'b1;
            mem[s_idx] = wb.dat_o;
          end
        end else begin
          s_rd  = mem[s_idx];
          s_ack = 1'b1;
          if (mode == M_CORRUPT && wb.adr_o == 16'h2005) s_rd = s_rd ^ 32'h1;
          if (mode == M_ERR && wb.adr_o == 16'h2007) s_err = 1'b1;
        end
      end
      wb.ack_i = s_ack;
      wb.err_i = s_err;
      wb.dat_i = s_rd;
    end
  end

  task automatic check_beat();
    beat_t e;
    beat_t g;
    vectors++;
    g.we  = wb.we_o;
    g.adr = wb.adr_o;
    g.dat = wb.we_o ? wb.dat_o : 32'h0;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL beat_unexpected: got we=%0b adr=%h, required no beat", g.we, g.adr);
    end else begin
      e = exp_q.pop_front();
      if (!e.we) e.dat = 32'h0;
      if (g !== e || wb.sel_o !== 4'hf) begin
        fails++;
        $display("FAIL beat: got we=%0b adr=%h dat=%h sel=%h, required we=%0b adr=%h dat=%h sel=f",
                 g.we, g.adr, g.dat, wb.sel_o, e.we, e.adr, e.dat);
      end
    end
  endtask

  // Monitor: a beat completes on a response or after TMO unanswered strobe cycles.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        hold        = 0;
        expect_drop = 1'b0;
      end else if (expect_drop) begin
        expect_drop = 1'b0;
        chk("timeout_drop", 64'({wb.cyc_o, wb.stb_o}), 64'(2'b00));
      end else if (wb.cyc_o && wb.stb_o) begin
        if (wb.ack_i || wb.err_i) begin
          hold = 0;
          check_beat();
        end else begin
          hold++;
          if (hold == TMO) begin
            hold        = 0;
            expect_drop = 1'b1;
            check_beat();
          end
        end
      end
    end
  end

  task automatic apply_reset(input mode_e m);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    mode  = m;
    repeat (3) @(posedge clk);
    exp_q.delete();
    push_sweep();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic finish_test(input string name, input logic [15:0] e_err,
                             input logic [15:0] e_mism, input logic e_pass,
                             input int unsigned budget);
    int unsigned n;
    n = 0;
    while (!done && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk({name, "_done"}, 64'(done), 64'(1'b1));
    chk({name, "_queue_left"}, 64'(exp_q.size()), 64'(0));
    chk({name, "_err_cnt"}, 64'(err_cnt), 64'(e_err));
    chk({name, "_mismatch_cnt"}, 64'(mism_cnt), 64'(e_mism));
    chk({name, "_pass"}, 64'(pass), 64'(e_pass));
    repeat (4) @(posedge clk);
    #1;
    chk({name, "_idle_after_done"}, 64'({wb.cyc_o, wb.stb_o, done}), 64'(3'b001));
  endtask

  initial begin
    int unsigned n;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_bus", 64'({wb.cyc_o, wb.stb_o, wb.we_o, wb.sel_o, wb.dat_o}), 64'(0));
    chk("reset_adr", 64'(wb.adr_o), 64'(16'h2000));
    chk("reset_status", 64'({done, pass, err_cnt, mism_cnt}), 64'(0));

    // Clean sweep, including first-beat latency after reset release.
    exp_q.delete();
    push_sweep();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("delay_idle", 64'(wb.cyc_o), 64'(1'b0));
    @(posedge clk);
    #1;
    chk("first_cycle", 64'({wb.cyc_o, wb.stb_o, wb.we_o, wb.adr_o, wb.dat_o}),
        64'({1'b1, 1'b1, 1'b1, 16'h2000, FIRST_DAT}));
    finish_test("normal", 16'd0, 16'd0, 1'b1, 400);

    // Read at 'h2005 corrupted in both loops.
    apply_reset(M_CORRUPT);
    finish_test("corrupt", 16'd0, 16'd2, 1'b0, 400);

    // err on write 'h2003 (data not stored, readback fails) and ack&err on read 'h2007.
    apply_reset(M_ERR);
    finish_test("slave_err", 16'd4, 16'd2, 1'b0, 400);

    // No responses at all: every beat times out.
    apply_reset(M_NOACK);
    finish_test("timeout", 16'd64, 16'd0, 1'b0, 2500);

    // Reset in the middle of the first read phase, then a clean rerun.
    apply_reset(M_CORRUPT);
    n = 0;
    while (mism_cnt != 16'd1 && n < 400) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("mid_read_mismatch", 64'({mism_cnt, wb.we_o, wb.cyc_o}), 64'({16'd1, 1'b0, 1'b1}));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_bus", 64'({wb.cyc_o, wb.stb_o}), 64'(2'b00));
    chk("async_reset_adr", 64'(wb.adr_o), 64'(16'h2000));
    chk("async_reset_counts", 64'({done, err_cnt, mism_cnt}), 64'(0));
    apply_reset(M_NORMAL);
    finish_test("restart", 16'd0, 16'd0, 1'b1, 400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
